// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file's single write port.
// Ports: in_* push handshake, wb_stall/WE3/WA3/WD3 drain port,
// RAn/fwdn_* newest-pending bypass, count/empty/full status.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int AW    = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [AW-1:0]              in_addr,
   input  logic [XLEN-1:0]            in_data,
   input  logic                       wb_stall,
   output logic                       WE3,
   output logic [AW-1:0]              WA3,
   output logic [XLEN-1:0]            WD3,
   input  logic [AW-1:0]              RA1,
   input  logic [AW-1:0]              RA2,
   output logic                       fwd1_hit,
   output logic                       fwd2_hit,
   output logic [XLEN-1:0]            fwd1_data,
   output logic [XLEN-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]   addr_q [DEPTH];
   logic [AW-1:0]   addr_d [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] data_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic pop;
   logic push;
   logic enq;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign count    = count_q;
   assign pop      = !empty && !wb_stall;
   assign in_ready = !full || pop;
   assign push     = in_valid && in_ready;
   // x0 writes complete the handshake but are never stored
   assign enq      = push && (in_addr != '0);

   assign WE3 = pop;
   assign WA3 = pop ? addr_q[rd_ptr_q] : '0;
   assign WD3 = pop ? data_q[rd_ptr_q] : '0;

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) begin
         addr_d[wr_ptr_q] = in_addr;
         data_d[wr_ptr_q] = in_data;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({enq, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Scan oldest to newest so the newest match overwrites older ones.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd2_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q) begin
            if (RA1 != '0 && addr_q[rd_ptr_q + PW'(i)] == RA1) begin
               fwd1_hit  = 1'b1;
               fwd1_data = data_q[rd_ptr_q + PW'(i)];
            end
            if (RA2 != '0 && addr_q[rd_ptr_q + PW'(i)] == RA2) begin
               fwd2_hit  = 1'b1;
               fwd2_data = data_q[rd_ptr_q + PW'(i)];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomised + directed bench for regfile_wb_queue against a queue model.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_addr;
   logic [XLEN-1:0] in_data;
   logic            wb_stall;
   logic            WE3;
   logic [AW-1:0]   WA3;
   logic [XLEN-1:0] WD3;
   logic [AW-1:0]   RA1, RA2;
   logic            fwd1_hit, fwd2_hit;
   logic [XLEN-1:0] fwd1_data, fwd2_data;
   logic [$clog2(DEPTH):0] count;
   logic            empty, full;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0]   qa[$];
   logic [XLEN-1:0] qd[$];

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data),
      .wb_stall(wb_stall),
      .WE3(WE3), .WA3(WA3), .WD3(WD3),
      .RA1(RA1), .RA2(RA2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .count(count), .empty(empty), .full(full)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_fwd(input logic [AW-1:0] ra,
                                     output logic hit,
                                     output logic [XLEN-1:0] dat);
      hit = 1'b0;
      dat = '0;
      if (ra != 0) begin
         for (int i = qa.size() - 1; i >= 0; i--) begin
            if (qa[i] == ra) begin
               hit = 1'b1;
               dat = qd[i];
               break;
            end
         end
      end
   endfunction

   task automatic check_reset_outputs();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_we3", WE3, 0);
      chk("rst_wa3", WA3, 0);
      chk("rst_wd3", WD3, 0);
      chk("rst_hit1", fwd1_hit, 0);
      chk("rst_hit2", fwd2_hit, 0);
      chk("rst_fd1", fwd1_data, 0);
      chk("rst_fd2", fwd2_data, 0);
   endtask

   // One clock cycle: drive, compare against model, clock, update model.
   task automatic cycle(input logic v, input logic [AW-1:0] a,
                        input logic [XLEN-1:0] d, input logic st,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        output logic acc);
      logic            e_pop, e_rdy, h;
      logic [XLEN-1:0] fd;
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      wb_stall = st;
      RA1      = r1;
      RA2      = r2;
      #1;
      e_pop = (qa.size() > 0) && !st;
      e_rdy = (qa.size() < DEPTH) || e_pop;
      chk("we3", WE3, e_pop);
      chk("wa3", WA3, e_pop ? qa[0] : '0);
      chk("wd3", WD3, e_pop ? qd[0] : '0);
      chk("ready", in_ready, e_rdy);
      chk("count", count, qa.size());
      chk("empty", empty, qa.size() == 0);
      chk("full", full, qa.size() == DEPTH);
      model_fwd(r1, h, fd);
      chk("hit1", fwd1_hit, h);
      chk("fd1", fwd1_data, fd);
      model_fwd(r2, h, fd);
      chk("hit2", fwd2_hit, h);
      chk("fd2", fwd2_data, fd);
      acc = v && in_ready;
      @(posedge clk);
      if (e_pop) begin
         void'(qa.pop_front());
         void'(qd.pop_front());
      end
      if (v && e_rdy && a != 0) begin
         qa.push_back(a);
         qd.push_back(d);
      end
      @(negedge clk);
   endtask

   initial begin
      logic acc;
      int   pushes;
      int   guard;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      wb_stall = 1'b0;
      RA1      = '0;
      RA2      = '0;
      #2;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // single write
      cycle(1, 5, 32'hDEADBEEF, 0, 5, 0, acc);
      chk("single_acc", acc, 1);
      cycle(0, 0, 0, 0, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, acc);

      // x0 drop
      cycle(1, 0, 32'h12345678, 0, 0, 0, acc);
      chk("x0_acc", acc, 1);
      cycle(0, 0, 0, 0, 0, 0, acc);
      chk("x0_count", count, 0);

      // stall fill
      for (int i = 1; i <= 4; i++)
         cycle(1, AW'(i), XLEN'(i * 'h11), 1, AW'(i), 0, acc);
      cycle(1, 6, 32'h66, 1, 3, 4, acc);
      chk("fill_5th_rej", acc, 0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 4);
      cycle(1, 6, 32'h66, 0, 6, 1, acc);
      chk("release_acc", acc, 1);
      for (int i = 0; i < 5; i++)
         cycle(0, 0, 0, 0, 6, 0, acc);

      // forward newest
      cycle(1, 7, 32'hA, 1, 7, 0, acc);
      cycle(1, 7, 32'hB, 1, 7, 0, acc);
      cycle(0, 0, 0, 1, 7, 0, acc);
      chk("fwd_new_hit", fwd1_hit, 1);
      chk("fwd_new_data", fwd1_data, 32'hB);
      cycle(0, 0, 0, 0, 7, 0, acc);
      cycle(0, 0, 0, 0, 7, 0, acc);
      cycle(0, 0, 0, 0, 7, 0, acc);
      #1;
      chk("fwd_drained", fwd1_hit, 0);
      @(negedge clk);

      // randomised wrap-around
      pushes = 0;
      guard  = 0;
      while (pushes < 3 * DEPTH && guard < 400) begin
         logic v;
         v = ($urandom_range(0, 3) != 0);
         cycle(v, AW'($urandom_range(0, 31)), $urandom,
               ($urandom_range(0, 2) == 0),
               AW'($urandom_range(0, 31)), AW'($urandom_range(0, 7)),
               acc);
         if (acc) pushes++;
         chk("cnt_le_depth", count <= DEPTH, 1);
         guard++;
      end
      chk("wrap_done", pushes >= 3 * DEPTH, 1);
      for (int i = 0; i < 6; i++)
         cycle(0, 0, 0, 0, AW'($urandom_range(0, 31)), 0, acc);

      // reset mid-operation
      for (int i = 0; i < 3; i++)
         cycle(1, AW'(10 + i), XLEN'(i + 'h100), 1, 0, 0, acc);
      chk("pre_rst_count", count, 3);
      in_valid = 1'b0;
      wb_stall = 1'b0;
      RA1      = 10;
      RA2      = 11;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      qa.delete();
      qd.delete();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         cycle(0, 0, 0, 0, 10, 12, acc);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue in front of the register file's single write port. It accepts write-back requests (destination register, data) from the execute/memory stages through a valid/ready handshake and buffers them in an in-order FIFO. It drains one entry per cycle onto the register file's write port (`WE3`/`WA3`/`WD3`). It also forwards the newest still-pending value for two read addresses, so the register file's read ports plus this bypass always return architecturally current data.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥ 2
- `XLEN`, 32, data width
- `AW`, 5, register address width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  write-back request present
- `in_ready`  out  1  queue can accept the request this cycle
- `in_addr`  in  AW  destination register
- `in_data`  in  XLEN  write-back value
- `wb_stall`  in  1  register-file write port unavailable this cycle; hold head entry
- `WE3`  out  1  register-file write enable
- `WA3`  out  AW  register-file write address
- `WD3`  out  XLEN  register-file write data
- `RA1`, `RA2`  in  AW  lookup addresses; same addresses as the register-file read ports
- `fwd1_hit`, `fwd2_hit`  out  1  a pending entry matches `RA1` / `RA2`
- `fwd1_data`, `fwd2_data`  out  XLEN  newest pending value for `RA1` / `RA2`; 0 when no hit
- `count`  out  $clog2(DEPTH)+1  number of pending entries
- `empty`, `full`  out  1  FIFO status

## Operation
- **Storage.** Circular FIFO of {addr, data}, with write pointer, read pointer and count.
  - Pointers wrap modulo `DEPTH`.
  - `count` is held explicitly; full/empty are never derived from pointer equality alone.
- **Push.** Push occurs when `in_valid && in_ready`.
  - If `in_addr == 0`, the handshake completes but nothing is enqueued, so x0 writes are dropped.
  - Otherwise {in_addr, in_data} is written at the write pointer and the write pointer advances.
- **Pop.** `pop = !empty && !wb_stall`.
  - Drive `WE3 = pop`, with `WA3`/`WD3` = head entry (combinational from the head).
  - When `WE3` = 0, `WA3`/`WD3` = 0.
  - On the edge where `pop` = 1, the read pointer advances.
- **Ready.** `in_ready = !full || pop`. Push and pop in the same cycle are legal when full.
  - When full with a simultaneous push and pop, count is unchanged.
- **Count update.** Per edge: +1 for an enqueuing push, −1 for a pop, unchanged for both or neither.
  - A dropped x0 push never changes count.
- **Forwarding.**
  - Combinationally search all pending entries, including the head even while it is being written this cycle.
  - Match is on `addr == RAn`; the newest (closest to the write pointer) match wins.
  - `RAn == 0` never hits.
  - An incoming same-cycle push is not forwarded; it is visible from the next cycle.
- **Ordering.** Entries retire strictly in acceptance order. Duplicate addresses are allowed and each is written in turn.
- **No internal FSM beyond the FIFO.** States are the derived conditions EMPTY (count=0), PARTIAL, and FULL (count=DEPTH).

## Timing
- **Reset (async assert, sync-safe deassert).**
  - Pointers and count become 0; all pending entries are discarded.
  - `empty`=1, `full`=0, `count`=0, `in_ready`=1, `WE3`=0, `WA3`=0, `WD3`=0, `fwd*_hit`=0, `fwd*_data`=0.
  - Reset asserted mid-drain aborts immediately, and no further `WE3` pulses occur.
- **Latency.** A request accepted at edge N into an empty queue appears on `WE3` during cycle N→N+1. It is written into the register file at edge N+1.
- **Throughput.** With `wb_stall`=0, one entry per cycle sustained and the queue never exceeds 1 entry.
- **Stall.** While `wb_stall`=1 the head is held and `WE3`=0. The queue absorbs up to `DEPTH` requests, then `in_ready`=0.
- **Release.** On the first cycle `wb_stall` returns to 0 while full, `in_ready`=1 in that same cycle.
- **Wrap-around.** Pointer wrap from `DEPTH-1` to 0 must be seamless under continuous push and pop.

## Test plan
- **Single write.** After reset, push (addr=5, data=0xDEADBEEF) once. Required: the next cycle shows `WE3`=1, `WA3`=5, `WD3`=0xDEADBEEF; then `empty`=1 and `count`=0.
- **x0 drop.** Push addr=0, data=0x12345678. Required: `in_ready`=1 and handshake accepted, `count` stays 0, `WE3` never asserts.
- **Stall fill.** Hold `wb_stall`=1 and push addrs 1,2,3,4 with data 0x11..0x44.
  - Required: `full`=1, `count`=4, `in_ready`=0, fifth push not accepted.
  - Then release the stall with a fifth push (addr=6) held: `in_ready`=1 that cycle, and `WA3` sequence 1,2,3,4,6 on consecutive cycles.
- **Forward newest.** Under stall, push (7, 0xA), then (7, 0xB). Set `RA1`=7, `RA2`=0.
  - Required: `fwd1_hit`=1, `fwd1_data`=0xB, `fwd2_hit`=0.
  - After both drain: `fwd1_hit`=0.
- **Wrap-around.** Run 3·`DEPTH` pushes with random `wb_stall`. Required: `WA3`/`WD3` sequence equals the accepted non-x0 sequence exactly, and `count` never exceeds `DEPTH`.
- **Reset mid-operation.** With 3 entries pending, pulse `rst_n`=0 asynchronously (between edges). Required: outputs go to reset values immediately, and no `WE3` occurs after deassertion.
